// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing the core data-memory port between the LSU (M0) and the debug/DMA engine (M1).
// An in-order ID FIFO remembers who owns each outstanding request so responses route back to the issuer.
module data_bus_arbiter #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_error,
    output logic        unexp_rsp
);

    localparam int                 PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(MAX_OUTST - 1);

    logic                 rr_ptr_q, rr_ptr_d;
    logic                 lock_q, lock_d;
    logic                 lock_owner_q, lock_owner_d;
    logic                 unexp_q, unexp_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTST-1:0] id_mem_q, id_mem_d;

    logic sel;
    logic sel_req;
    logic sel_lock;
    logic grant;
    logic pop;
    logic fifo_empty;
    logic head_id;

    // A held lock pins the owner; otherwise a lone requester wins and ties go to rr_ptr.
    always_comb begin
        sel = rr_ptr_q;
        if (lock_q) begin
            sel = lock_owner_q;
        end else if (m0_req && !m1_req) begin
            sel = 1'b0;
        end else if (m1_req && !m0_req) begin
            sel = 1'b1;
        end
        sel_req  = sel ? m1_req  : m0_req;
        sel_lock = sel ? m1_lock : m0_lock;
    end

    assign fifo_empty = (count_q == '0);
    assign head_id    = id_mem_q[rd_ptr_q];
    assign pop        = bus_valid && !fifo_empty;

    // Full is judged on the registered count only, so a same-cycle response never frees a slot early.
    assign bus_req = sel_req && (count_q < MAX_CNT);
    assign grant   = bus_req && bus_gnt;

    always_comb begin
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_be    = '0;
        if (sel_req) begin
            bus_wr    = sel ? m1_wr    : m0_wr;
            bus_addr  = sel ? m1_addr  : m0_addr;
            bus_wdata = sel ? m1_wdata : m0_wdata;
            bus_be    = sel ? m1_be    : m0_be;
        end
    end

    assign m0_gnt    = grant && !sel;
    assign m1_gnt    = grant && sel;
    assign m0_valid  = pop && !head_id;
    assign m1_valid  = pop && head_id;
    assign m0_err    = m0_valid && bus_error;
    assign m1_err    = m1_valid && bus_error;
    assign m0_rdata  = bus_rdata;
    assign m1_rdata  = bus_rdata;
    assign unexp_rsp = unexp_q;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        unexp_d      = unexp_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        id_mem_d     = id_mem_q;

        if (grant) begin
            id_mem_d[wr_ptr_q] = sel;
            wr_ptr_d           = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            lock_d             = sel_lock;
            lock_owner_d       = sel;
            // The round-robin pointer only moves once a locked pair has completed.
            if (!sel_lock) begin
                rr_ptr_d = ~sel;
            end
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({grant, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (bus_valid && fifo_empty) begin
            unexp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= 1'b0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            unexp_q      <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            id_mem_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            unexp_q      <= unexp_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            id_mem_q     <= id_mem_d;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Testbench for data_bus_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based model of ownership, fairness and locking.
module tb_data_bus_arbiter;

    localparam int MAX_OUTST = 2;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m0_lock, m0_wr;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_be;
    logic        m0_gnt, m0_valid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_lock, m1_wr;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_be;
    logic        m1_gnt, m1_valid, m1_err;
    logic [31:0] m1_rdata;
    logic        bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_valid, bus_error;
    logic [31:0] bus_rdata;
    logic        unexp_rsp;

    int compared   = 0;
    int mismatched = 0;

    data_bus_arbiter #(.MAX_OUTST(MAX_OUTST), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_wr(m0_wr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_valid(m0_valid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wr(m1_wr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_valid(m1_valid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_valid(bus_valid), .bus_rdata(bus_rdata),
        .bus_error(bus_error), .unexp_rsp(unexp_rsp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model state: owners of outstanding requests in issue order, preferred master, lock holder.
    int   owners[$];
    int   pref_m;
    int   lock_own;
    logic unexp_m;
    logic exp_g0, exp_g1;
    int   msel;
    int   mhead;
    logic m_rs, m_ls, m_breq, m_g, m_pv;

    always @(negedge clk) begin
        if (!reset_n) begin
            owners.delete();
            pref_m   = 0;
            lock_own = -1;
            unexp_m  = 1'b0;
            exp_g0   = 1'b0;
            exp_g1   = 1'b0;
            checkOutput("rst_m0_gnt",    32'(m0_gnt),    32'd0);
            checkOutput("rst_m1_gnt",    32'(m1_gnt),    32'd0);
            checkOutput("rst_m0_valid",  32'(m0_valid),  32'd0);
            checkOutput("rst_m1_valid",  32'(m1_valid),  32'd0);
            checkOutput("rst_unexp_rsp", 32'(unexp_rsp), 32'd0);
        end else begin
            if (lock_own >= 0)           msel = lock_own;
            else if (m0_req && !m1_req)  msel = 0;
            else if (m1_req && !m0_req)  msel = 1;
            else                         msel = pref_m;
            m_rs   = (msel == 1) ? m1_req  : m0_req;
            m_ls   = (msel == 1) ? m1_lock : m0_lock;
            m_breq = m_rs && (owners.size() < MAX_OUTST);
            m_g    = m_breq && bus_gnt;
            m_pv   = bus_valid && (owners.size() > 0);
            mhead  = m_pv ? owners[0] : -1;

            checkOutput("bus_req",   32'(bus_req),   32'(m_breq));
            checkOutput("m0_gnt",    32'(m0_gnt),    32'(m_g && msel == 0));
            checkOutput("m1_gnt",    32'(m1_gnt),    32'(m_g && msel == 1));
            checkOutput("m0_valid",  32'(m0_valid),  32'(mhead == 0));
            checkOutput("m1_valid",  32'(m1_valid),  32'(mhead == 1));
            checkOutput("m0_err",    32'(m0_err),    32'(mhead == 0 && bus_error));
            checkOutput("m1_err",    32'(m1_err),    32'(mhead == 1 && bus_error));
            checkOutput("m0_rdata",  m0_rdata,       bus_rdata);
            checkOutput("m1_rdata",  m1_rdata,       bus_rdata);
            checkOutput("unexp_rsp", 32'(unexp_rsp), 32'(unexp_m));
            if (m_breq) begin
                checkOutput("bus_wr",    32'(bus_wr),   32'((msel == 1) ? m1_wr : m0_wr));
                checkOutput("bus_addr",  bus_addr,      (msel == 1) ? m1_addr  : m0_addr);
                checkOutput("bus_wdata", bus_wdata,     (msel == 1) ? m1_wdata : m0_wdata);
                checkOutput("bus_be",    32'(bus_be),   32'((msel == 1) ? m1_be : m0_be));
            end

            if (bus_valid && owners.size() == 0) unexp_m = 1'b1;
            if (m_pv) void'(owners.pop_front());
            if (m_g) begin
                owners.push_back(msel);
                if (m_ls) begin
                    lock_own = msel;
                end else begin
                    lock_own = -1;
                    pref_m   = 1 - msel;
                end
            end
            exp_g0 = m_g && msel == 0;
            exp_g1 = m_g && msel == 1;
        end
    end

    // Directed cycle: drive one set of inputs just after the clock edge, then settle to mid-cycle.
    task automatic applyStimulus(input logic r0, input logic l0, input logic r1, input logic l1,
                                 input logic bg, input logic bv, input logic berr);
        @(posedge clk);
        #1;
        m0_req = r0;  m0_lock = l0;  m0_wr = 1'b0;  m0_addr = 32'h0000_1000;
        m0_wdata = 32'hA0A0_0000;  m0_be = 4'hF;
        m1_req = r1;  m1_lock = l1;  m1_wr = 1'b1;  m1_addr = 32'h0000_2004;
        m1_wdata = 32'hB1B1_0001;  m1_be = 4'h3;
        bus_gnt = bg;  bus_valid = bv;  bus_error = berr;  bus_rdata = 32'hCAFE_0000;
        @(negedge clk);
    endtask

    task automatic clearInputs();
        m0_req = 0; m0_lock = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_lock = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
        bus_gnt = 0; bus_valid = 0; bus_error = 0; bus_rdata = 0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        clearInputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_bus_req", 32'(bus_req),   32'd0);
        checkOutput("reset_unexp",   32'(unexp_rsp), 32'd0);

        // M0 alone: three back-to-back reads, each answered one cycle later.
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("t1_c1_m0_gnt",   32'(m0_gnt),   32'd1);
        checkOutput("t1_c1_m0_valid", 32'(m0_valid), 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 1, 0);
        checkOutput("t1_c2_m0_gnt",   32'(m0_gnt),   32'd1);
        checkOutput("t1_c2_m0_valid", 32'(m0_valid), 32'd1);
        checkOutput("t1_c2_m1_valid", 32'(m1_valid), 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 1, 0);
        checkOutput("t1_c3_m0_gnt",   32'(m0_gnt),   32'd1);
        checkOutput("t1_c3_m0_valid", 32'(m0_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("t1_c4_m0_valid", 32'(m0_valid), 32'd1);
        checkOutput("t1_c4_m1_valid", 32'(m1_valid), 32'd0);

        // Both masters from reset: alternate M0, M1, M0, M1 with responses in the same order.
        doReset();
        applyStimulus(1, 0, 1, 0, 1, 0, 0);
        checkOutput("t2_c1_m0_gnt",   32'(m0_gnt),   32'd1);
        checkOutput("t2_c1_m1_gnt",   32'(m1_gnt),   32'd0);
        applyStimulus(1, 0, 1, 0, 1, 1, 0);
        checkOutput("t2_c2_m1_gnt",   32'(m1_gnt),   32'd1);
        checkOutput("t2_c2_m0_valid", 32'(m0_valid), 32'd1);
        applyStimulus(1, 0, 1, 0, 1, 1, 0);
        checkOutput("t2_c3_m0_gnt",   32'(m0_gnt),   32'd1);
        checkOutput("t2_c3_m1_valid", 32'(m1_valid), 32'd1);
        applyStimulus(1, 0, 1, 0, 1, 1, 0);
        checkOutput("t2_c4_m1_gnt",   32'(m1_gnt),   32'd1);
        checkOutput("t2_c4_m0_valid", 32'(m0_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("t2_c5_m1_valid", 32'(m1_valid), 32'd1);

        // Locked pair: M0 keeps the bus for its second half even though M1 is waiting.
        applyStimulus(1, 1, 1, 0, 1, 0, 0);
        checkOutput("t3_c1_m0_gnt",   32'(m0_gnt),   32'd1);
        applyStimulus(1, 0, 1, 0, 1, 1, 0);
        checkOutput("t3_c2_m0_gnt",   32'(m0_gnt),   32'd1);
        checkOutput("t3_c2_m1_gnt",   32'(m1_gnt),   32'd0);
        applyStimulus(0, 0, 1, 0, 1, 1, 0);
        checkOutput("t3_c3_m1_gnt",   32'(m1_gnt),   32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("t3_c4_m1_valid", 32'(m1_valid), 32'd1);

        // Full: two grants, then held off even while a response pops, resuming the cycle after.
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("t4_c2_m0_gnt",   32'(m0_gnt),   32'd1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("t4_c3_bus_req",  32'(bus_req),  32'd0);
        applyStimulus(1, 0, 0, 0, 1, 1, 0);
        checkOutput("t4_c4_bus_req",  32'(bus_req),  32'd0);
        checkOutput("t4_c4_m0_valid", 32'(m0_valid), 32'd1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("t4_c5_m0_gnt",   32'(m0_gnt),   32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);

        // Error response on an M1-owned head.
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        checkOutput("t5_c1_m1_gnt",   32'(m1_gnt),   32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("t5_c2_m1_valid", 32'(m1_valid), 32'd1);
        checkOutput("t5_c2_m1_err",   32'(m1_err),   32'd1);
        checkOutput("t5_c2_m0_valid", 32'(m0_valid), 32'd0);
        checkOutput("t5_c2_m0_err",   32'(m0_err),   32'd0);

        // Response with nothing outstanding sets the sticky flag until reset.
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("t6_c1_m0_valid", 32'(m0_valid),  32'd0);
        checkOutput("t6_c1_m1_valid", 32'(m1_valid),  32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_c2_unexp",    32'(unexp_rsp), 32'd1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("t6_c3_unexp",    32'(unexp_rsp), 32'd1);
        doReset();
        checkOutput("t6_post_unexp",  32'(unexp_rsp), 32'd0);

        // Response arriving after a mid-flight reset is unexpected.
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("t7_c1_m0_gnt",   32'(m0_gnt),    32'd1);
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("t7_c2_m0_valid", 32'(m0_valid),  32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t7_c3_unexp",    32'(unexp_rsp), 32'd1);
        doReset();

        // Random traffic: requests stay held with their attributes until granted.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            #1;
            if (!(m0_req && !exp_g0)) begin
                m0_req   = ($urandom_range(0, 9) < 6);
                m0_lock  = ($urandom_range(0, 3) == 0);
                m0_wr    = 1'($urandom);
                m0_addr  = $urandom;
                m0_wdata = $urandom;
                m0_be    = 4'($urandom);
            end
            if (!(m1_req && !exp_g1)) begin
                m1_req   = ($urandom_range(0, 9) < 5);
                m1_lock  = ($urandom_range(0, 3) == 0);
                m1_wr    = 1'($urandom);
                m1_addr  = $urandom;
                m1_wdata = $urandom;
                m1_be    = 4'($urandom);
            end
            bus_gnt   = ($urandom_range(0, 9) < 7);
            bus_valid = (owners.size() > 0) ? ($urandom_range(0, 9) < 4)
                                            : ($urandom_range(0, 99) == 0);
            bus_error = ($urandom_range(0, 7) == 0);
            bus_rdata = $urandom;
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
